// File: rtl/fifo_fwft_reader.sv
// First-word-fall-through read adapter for the async FIFO read port, with a 2-entry skid buffer.
// Optional flush_i port is enabled by defining FWFT_READER_FLUSH_EN.
module fifo_fwft_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef FWFT_READER_FLUSH_EN
    input  logic                  flush_i,
`endif
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_read_o,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i
);

    logic                  flush;
    logic [1:0]            cnt;
    logic [1:0]            cnt_next;
    logic                  inflight;
    logic                  pop;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;

`ifdef FWFT_READER_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Occupancy after this cycle counts the in-flight word as already owned,
    // so a read is only issued when a buffer slot is guaranteed for it.
    always_comb begin
        // NOTE: every always_comb output is assigned on every path so no latch can be inferred.
        m_valid_o   = (cnt != 2'd0) && !flush;
        pop         = m_valid_o && m_ready_i;
        cnt_next    = cnt + {1'b0, inflight} - {1'b0, pop};
        fifo_read_o = !rst_i && !flush && !fifo_empty_i && (cnt_next < 2'd2);
    end

    assign m_data_o = buf0;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst_i || flush) begin
            cnt      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            inflight <= fifo_read_o;
        end
    end

    // NOTE: the data buffer has no reset; cnt alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush) begin
            if (inflight) begin
                // Arriving word lands in the first free slot after this cycle's pop.
                case (cnt)
                    2'd0: buf0 <= fifo_data_i;
                    2'd1: begin
                        if (pop) buf0 <= fifo_data_i;
                        else     buf1 <= fifo_data_i;
                    end
                    default: begin
                        buf0 <= buf1;
                        buf1 <= fifo_data_i;
                    end
                endcase
            end else if (pop) begin
                buf0 <= buf1;
            end
        end
    end

    cnt_inflight_bound: assert property (
        @(posedge clk_i) disable iff (rst_i)
        ({1'b0, cnt} + {2'b00, inflight}) <= 3'd2
    );

endmodule
